// File: rtl/cavlc_pkg.sv
// rtl/cavlc_pkg.sv - coeff_token VLC types and lookup tables
package cavlc_pkg;

    localparam int CODE_W = 16;
    localparam int LEN_W  = 5;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [CODE_W-1:0] code;
    } vlc_t;

    typedef enum logic [1:0] {TBL_CDC, TBL_A, TBL_B} tbl_sel_e;

    // Keys are {TotalCoeff, TrailingOnes}; unlisted keys are unreachable or illegal.
    function automatic vlc_t vlc_a(input logic [5:0] key);
        vlc_t v;
        case (key)
            6'd0:  v = {5'd1, 16'd1};
            6'd4:  v = {5'd6, 16'd5};   6'd5:  v = {5'd2, 16'd1};
            6'd8:  v = {5'd8, 16'd7};   6'd9:  v = {5'd6, 16'd4};   6'd10: v = {5'd3, 16'd1};
            6'd12: v = {5'd9, 16'd7};   6'd13: v = {5'd8, 16'd6};   6'd14: v = {5'd7, 16'd5};   6'd15: v = {5'd5, 16'd3};
            6'd16: v = {5'd10, 16'd7};  6'd17: v = {5'd9, 16'd6};   6'd18: v = {5'd8, 16'd5};   6'd19: v = {5'd6, 16'd3};
            6'd20: v = {5'd11, 16'd7};  6'd21: v = {5'd10, 16'd6};  6'd22: v = {5'd9, 16'd5};   6'd23: v = {5'd7, 16'd4};
            6'd24: v = {5'd13, 16'd15}; 6'd25: v = {5'd11, 16'd6};  6'd26: v = {5'd10, 16'd5};  6'd27: v = {5'd8, 16'd4};
            6'd28: v = {5'd13, 16'd11}; 6'd29: v = {5'd13, 16'd14}; 6'd30: v = {5'd11, 16'd5};  6'd31: v = {5'd9, 16'd4};
            6'd32: v = {5'd13, 16'd8};  6'd33: v = {5'd13, 16'd10}; 6'd34: v = {5'd13, 16'd13}; 6'd35: v = {5'd10, 16'd4};
            6'd36: v = {5'd14, 16'd15}; 6'd37: v = {5'd14, 16'd14}; 6'd38: v = {5'd13, 16'd9};  6'd39: v = {5'd11, 16'd4};
            6'd40: v = {5'd14, 16'd11}; 6'd41: v = {5'd14, 16'd10}; 6'd42: v = {5'd14, 16'd13}; 6'd43: v = {5'd13, 16'd12};
            6'd44: v = {5'd15, 16'd15}; 6'd45: v = {5'd15, 16'd14}; 6'd46: v = {5'd14, 16'd9};  6'd47: v = {5'd14, 16'd12};
            6'd48: v = {5'd15, 16'd11}; 6'd49: v = {5'd15, 16'd10}; 6'd50: v = {5'd15, 16'd13}; 6'd51: v = {5'd14, 16'd8};
            6'd52: v = {5'd16, 16'd15}; 6'd53: v = {5'd15, 16'd1};  6'd54: v = {5'd15, 16'd9};  6'd55: v = {5'd15, 16'd12};
            6'd56: v = {5'd16, 16'd11}; 6'd57: v = {5'd16, 16'd14}; 6'd58: v = {5'd16, 16'd13}; 6'd59: v = {5'd15, 16'd8};
            6'd60: v = {5'd16, 16'd7};  6'd61: v = {5'd16, 16'd10}; 6'd62: v = {5'd16, 16'd9};  6'd63: v = {5'd16, 16'd12};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic vlc_t vlc_b(input logic [5:0] key);
        vlc_t v;
        case (key)
            6'd0:  v = {5'd2, 16'd3};
            6'd4:  v = {5'd6, 16'd11};  6'd5:  v = {5'd2, 16'd2};
            6'd8:  v = {5'd6, 16'd7};   6'd9:  v = {5'd5, 16'd7};   6'd10: v = {5'd3, 16'd3};
            6'd12: v = {5'd7, 16'd7};   6'd13: v = {5'd6, 16'd10};  6'd14: v = {5'd6, 16'd9};   6'd15: v = {5'd4, 16'd5};
            6'd16: v = {5'd8, 16'd7};   6'd17: v = {5'd6, 16'd6};   6'd18: v = {5'd6, 16'd5};   6'd19: v = {5'd4, 16'd4};
            6'd20: v = {5'd8, 16'd4};   6'd21: v = {5'd7, 16'd6};   6'd22: v = {5'd7, 16'd5};   6'd23: v = {5'd5, 16'd6};
            6'd24: v = {5'd9, 16'd7};   6'd25: v = {5'd8, 16'd6};   6'd26: v = {5'd8, 16'd5};   6'd27: v = {5'd6, 16'd8};
            6'd28: v = {5'd11, 16'd15}; 6'd29: v = {5'd9, 16'd6};   6'd30: v = {5'd9, 16'd5};   6'd31: v = {5'd6, 16'd4};
            6'd32: v = {5'd11, 16'd11}; 6'd33: v = {5'd11, 16'd14}; 6'd34: v = {5'd11, 16'd13}; 6'd35: v = {5'd7, 16'd4};
            6'd36: v = {5'd12, 16'd15}; 6'd37: v = {5'd11, 16'd10}; 6'd38: v = {5'd11, 16'd9};  6'd39: v = {5'd9, 16'd4};
            6'd40: v = {5'd12, 16'd11}; 6'd41: v = {5'd12, 16'd14}; 6'd42: v = {5'd12, 16'd13}; 6'd43: v = {5'd11, 16'd12};
            6'd44: v = {5'd12, 16'd8};  6'd45: v = {5'd12, 16'd10}; 6'd46: v = {5'd12, 16'd9};  6'd47: v = {5'd11, 16'd8};
            6'd48: v = {5'd13, 16'd15}; 6'd49: v = {5'd13, 16'd14}; 6'd50: v = {5'd13, 16'd13}; 6'd51: v = {5'd12, 16'd12};
            6'd52: v = {5'd13, 16'd11}; 6'd53: v = {5'd13, 16'd10}; 6'd54: v = {5'd13, 16'd9};  6'd55: v = {5'd13, 16'd12};
            6'd56: v = {5'd13, 16'd7};  6'd57: v = {5'd14, 16'd11}; 6'd58: v = {5'd13, 16'd6};  6'd59: v = {5'd13, 16'd8};
            6'd60: v = {5'd14, 16'd9};  6'd61: v = {5'd14, 16'd8};  6'd62: v = {5'd14, 16'd10}; 6'd63: v = {5'd13, 16'd1};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic vlc_t vlc_cdc(input logic [5:0] key);
        vlc_t v;
        case (key)
            6'd0:  v = {5'd2, 16'd1};
            6'd4:  v = {5'd6, 16'd7};   6'd5:  v = {5'd1, 16'd1};
            6'd8:  v = {5'd6, 16'd4};   6'd9:  v = {5'd6, 16'd6};   6'd10: v = {5'd3, 16'd1};
            6'd12: v = {5'd6, 16'd3};   6'd13: v = {5'd7, 16'd3};   6'd14: v = {5'd7, 16'd2};   6'd15: v = {5'd6, 16'd5};
            6'd16: v = {5'd6, 16'd2};   6'd17: v = {5'd8, 16'd3};   6'd18: v = {5'd8, 16'd2};   6'd19: v = {5'd7, 16'd0};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cavlc_coeff_token_encoder_if.sv
// rtl/cavlc_coeff_token_encoder_if.sv - encode request/result bundle
interface cavlc_coeff_token_encoder_if;
    import cavlc_pkg::*;

    logic                    axiiv;
    logic [3:0]              num_coeff;
    logic [1:0]              t1_s;
    logic                    nu_valid;
    logic [1:0]              nu;
    logic                    nl_valid;
    logic [1:0]              nl;
    logic                    is_chroma_DC;
    logic                    axiov;
    logic [LEN_W+CODE_W-1:0] axiod;

    modport master (
        output axiiv, num_coeff, t1_s, nu_valid, nu, nl_valid, nl, is_chroma_DC,
        input  axiov, axiod
    );

    modport slave (
        input  axiiv, num_coeff, t1_s, nu_valid, nu, nl_valid, nl, is_chroma_DC,
        output axiov, axiod
    );
endinterface

// File: rtl/cavlc_nc_select.sv
// rtl/cavlc_nc_select.sv - nC derivation from neighbour counts and table choice
module cavlc_nc_select
    import cavlc_pkg::*;
(
    input  logic       nu_valid,
    input  logic [1:0] nu,
    input  logic       nl_valid,
    input  logic [1:0] nl,
    input  logic       is_chroma_DC,
    output tbl_sel_e   tbl
);
    logic [2:0] sum;
    logic [2:0] nc;

    always_comb begin
        sum = 3'd1 + {1'b0, nu} + {1'b0, nl};
        nc  = 3'd0;
        if (nu_valid && nl_valid)
            nc = sum >> 1;
        else if (nu_valid)
            nc = {1'b0, nu};
        else if (nl_valid)
            nc = {1'b0, nl};

        if (is_chroma_DC)
            tbl = TBL_CDC;
        else if (nc >= 3'd2)
            tbl = TBL_B;
        else
            tbl = TBL_A;
    end
endmodule

// File: rtl/cavlc_coeff_token_encoder.sv
// rtl/cavlc_coeff_token_encoder.sv - coeff_token VLC lookup with one-cycle registered output
module cavlc_coeff_token_encoder
    import cavlc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    cavlc_coeff_token_encoder_if.slave bus
);
    tbl_sel_e   tbl;
    vlc_t       vlc;
    logic       illegal;
    logic [5:0] key;

    cavlc_nc_select u_nc_select (
        .nu_valid     (bus.nu_valid),
        .nu           (bus.nu),
        .nl_valid     (bus.nl_valid),
        .nl           (bus.nl),
        .is_chroma_DC (bus.is_chroma_DC),
        .tbl          (tbl)
    );

    always_comb begin
        key     = {bus.num_coeff, bus.t1_s};
        illegal = ({2'b00, bus.t1_s} > bus.num_coeff) ||
                  (bus.is_chroma_DC && (bus.num_coeff > 4'd4));
        case (tbl)
            TBL_CDC: vlc = vlc_cdc(key);
            TBL_B:   vlc = vlc_b(key);
            default: vlc = vlc_a(key);
        endcase
        // A zero length word marks the request as unencodable for the packer.
        if (illegal)
            vlc = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.axiov <= 1'b0;
            bus.axiod <= '0;
        end else if (bus.axiiv) begin
            bus.axiov <= 1'b1;
            bus.axiod <= vlc;
        end else begin
            bus.axiov <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cavlc_coeff_token_encoder.sv
// tb/tb_cavlc_coeff_token_encoder.sv - directed and randomized check against a bit-string table model
module tb_cavlc_coeff_token_encoder;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [20:0] prev_d;

    cavlc_coeff_token_encoder_if bus ();

    cavlc_coeff_token_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic string pick(input int t1, input string s0, input string s1,
                                   input string s2, input string s3);
        case (t1)
            0: return s0;
            1: return s1;
            2: return s2;
            default: return s3;
        endcase
    endfunction

    // Codewords as written in the standard's table, indexed by TotalCoeff then TrailingOnes.
    function automatic string str_a(input int tc, input int t1);
        case (tc)
            0:  return pick(t1, "1", "", "", "");
            1:  return pick(t1, "000101", "01", "", "");
            2:  return pick(t1, "00000111", "000100", "001", "");
            3:  return pick(t1, "000000111", "00000110", "0000101", "00011");
            4:  return pick(t1, "0000000111", "000000110", "00000101", "000011");
            5:  return pick(t1, "00000000111", "0000000110", "000000101", "0000100");
            6:  return pick(t1, "0000000001111", "00000000110", "0000000101", "00000100");
            7:  return pick(t1, "0000000001011", "0000000001110", "00000000101", "000000100");
            8:  return pick(t1, "0000000001000", "0000000001010", "0000000001101", "0000000100");
            9:  return pick(t1, "00000000001111", "00000000001110", "0000000001001", "00000000100");
            10: return pick(t1, "00000000001011", "00000000001010", "00000000001101", "0000000001100");
            11: return pick(t1, "000000000001111", "000000000001110", "00000000001001", "00000000001100");
            12: return pick(t1, "000000000001011", "000000000001010", "000000000001101", "00000000001000");
            13: return pick(t1, "0000000000001111", "000000000000001", "000000000001001", "000000000001100");
            14: return pick(t1, "0000000000001011", "0000000000001110", "0000000000001101", "000000000001000");
            default: return pick(t1, "0000000000000111", "0000000000001010", "0000000000001001", "0000000000001100");
        endcase
    endfunction

    function automatic string str_b(input int tc, input int t1);
        case (tc)
            0:  return pick(t1, "11", "", "", "");
            1:  return pick(t1, "001011", "10", "", "");
            2:  return pick(t1, "000111", "00111", "011", "");
            3:  return pick(t1, "0000111", "001010", "001001", "0101");
            4:  return pick(t1, "00000111", "000110", "000101", "0100");
            5:  return pick(t1, "00000100", "0000110", "0000101", "00110");
            6:  return pick(t1, "000000111", "00000110", "00000101", "001000");
            7:  return pick(t1, "00000001111", "000000110", "000000101", "000100");
            8:  return pick(t1, "00000001011", "00000001110", "00000001101", "0000100");
            9:  return pick(t1, "000000001111", "00000001010", "00000001001", "000000100");
            10: return pick(t1, "000000001011", "000000001110", "000000001101", "00000001100");
            11: return pick(t1, "000000001000", "000000001010", "000000001001", "00000001000");
            12: return pick(t1, "0000000001111", "0000000001110", "0000000001101", "000000001100");
            13: return pick(t1, "0000000001011", "0000000001010", "0000000001001", "0000000001100");
            14: return pick(t1, "0000000000111", "00000000001011", "0000000000110", "0000000001000");
            default: return pick(t1, "00000000001001", "00000000001000", "00000000001010", "0000000000001");
        endcase
    endfunction

    function automatic string str_c(input int tc, input int t1);
        case (tc)
            0: return pick(t1, "01", "", "", "");
            1: return pick(t1, "000111", "1", "", "");
            2: return pick(t1, "000100", "000110", "001", "");
            3: return pick(t1, "000011", "0000011", "0000010", "000101");
            default: return pick(t1, "000010", "00000011", "00000010", "0000000");
        endcase
    endfunction

    function automatic logic [20:0] ref_vlc(input int tc, input int t1, input bit nuv, input int nu,
                                            input bit nlv, input int nl, input bit cdc);
        int    nc;
        int    code;
        string s;
        if (t1 > tc || (cdc && tc > 4))
            return 21'd0;
        if (cdc)             nc = -1;
        else if (nuv && nlv) nc = (nu + nl + 1) / 2;
        else if (nuv)        nc = nu;
        else if (nlv)        nc = nl;
        else                 nc = 0;
        if (nc < 0)      s = str_c(tc, t1);
        else if (nc < 2) s = str_a(tc, t1);
        else             s = str_b(tc, t1);
        code = 0;
        for (int i = 0; i < s.len(); i++)
            code = (code << 1) | ((s[i] == 8'h31) ? 1 : 0);
        return {5'(s.len()), 16'(code)};
    endfunction

    task automatic do_cycle(input bit v, input logic [3:0] tc, input logic [1:0] t1,
                            input bit nuv, input logic [1:0] nu, input bit nlv,
                            input logic [1:0] nl, input bit cdc, input logic [20:0] exp,
                            input string tag);
        bus.axiiv        = v;
        bus.num_coeff    = tc;
        bus.t1_s         = t1;
        bus.nu_valid     = nuv;
        bus.nu           = nu;
        bus.nl_valid     = nlv;
        bus.nl           = nl;
        bus.is_chroma_DC = cdc;
        @(posedge clk);
        #1;
        check({tag, "_v"}, 32'(bus.axiov), 32'(v));
        if (v) begin
            check({tag, "_d"}, 32'(bus.axiod), 32'(exp));
            prev_d = exp;
        end else begin
            check({tag, "_hold"}, 32'(bus.axiod), 32'(prev_d));
        end
    endtask

    initial begin
        logic [3:0] tc;
        logic [1:0] t1, nu, nl;
        bit         v, nuv, nlv, cdc;
        n_cmp  = 0;
        n_err  = 0;
        prev_d = '0;
        rst    = 1'b0;
        bus.axiiv = 0; bus.num_coeff = 0; bus.t1_s = 0; bus.nu_valid = 0;
        bus.nu = 0; bus.nl_valid = 0; bus.nl = 0; bus.is_chroma_DC = 0;
        #12;
        check("rst_v", 32'(bus.axiov), 32'd0);
        check("rst_d", 32'(bus.axiod), 32'd0);
        #1 rst = 1'b1;

        for (int i = 0; i < 4; i++)
            do_cycle(1, 0, 0, 0, 0, 0, 0, 0, {5'd1, 16'h0001}, $sformatf("nc0_tc0_%0d", i));
        do_cycle(1, 1, 0, 0, 0, 0, 0, 0, {5'd6, 16'h0005}, "a_1_0");

        rst = 1'b0;
        #1;
        check("midrst_v", 32'(bus.axiov), 32'd0);
        check("midrst_d", 32'(bus.axiod), 32'd0);
        #2 rst = 1'b1;
        prev_d = '0;
        do_cycle(1, 2, 0, 0, 0, 0, 0, 0, {5'd8, 16'h0007}, "a_2_0");
        do_cycle(1, 2, 0, 1, 1, 1, 2, 0, {5'd6, 16'h0007}, "b_2_0");
        do_cycle(1, 0, 0, 0, 0, 1, 3, 0, {5'd2, 16'h0003}, "b_0_0");
        do_cycle(0, 5, 1, 0, 0, 0, 0, 0, 21'd0, "idle");
        do_cycle(1, 0, 0, 1, 3, 1, 3, 1, {5'd2, 16'h0001}, "cdc_0_0");
        do_cycle(1, 1, 1, 0, 0, 1, 2, 1, {5'd1, 16'h0001}, "cdc_1_1");
        do_cycle(1, 4, 0, 0, 0, 0, 0, 1, {5'd6, 16'h0002}, "cdc_4_0");
        do_cycle(1, 5, 0, 0, 0, 0, 0, 1, 21'd0, "cdc_tc5");
        do_cycle(1, 2, 3, 0, 0, 0, 0, 0, 21'd0, "t1_gt_tc");
        do_cycle(0, 2, 3, 0, 0, 0, 0, 0, 21'd0, "drop");

        for (int i = 0; i < 400; i++) begin
            v   = ($urandom_range(0, 9) < 8);
            cdc = ($urandom_range(0, 3) == 0);
            tc  = cdc ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)
                t1 = 2'($urandom_range(0, 3));
            else
                t1 = 2'($urandom_range(0, (tc < 3) ? int'(tc) : 3));
            nuv = 1'($urandom_range(0, 1));
            nlv = 1'($urandom_range(0, 1));
            nu  = 2'($urandom_range(0, 3));
            nl  = 2'($urandom_range(0, 3));
            do_cycle(v, tc, t1, nuv, nu, nlv, nl, cdc,
                     ref_vlc(int'(tc), int'(t1), nuv, int'(nu), nlv, int'(nl), cdc),
                     $sformatf("rnd%0d_tc%0d_t%0d_c%0d", i, tc, t1, cdc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
